// File: rtl/h80bus_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : h80bus_arb_pkg
// Purpose  : Shared types for the h80 bus two-master arbiter: arbiter state
//            encoding, master index type, default bus field types and a
//            helper that maps a master index to its ownership state.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package h80bus_arb_pkg;

  localparam int unsigned NUM_MASTERS = 2;

  // Default h80 bus field widths. The arbiter itself is parameterised and
  // sizes its ports from its own parameters.
  localparam int unsigned H80BUS_ADDR_WIDTH = 16;
  localparam int unsigned H80BUS_CMD_WIDTH  = 3;
  localparam int unsigned H80BUS_DATA_WIDTH = 32;

  typedef logic [H80BUS_ADDR_WIDTH-1:0] bus_addr_t;
  typedef logic [H80BUS_CMD_WIDTH-1:0]  bus_cmd_t;
  typedef logic [H80BUS_DATA_WIDTH-1:0] bus_data_t;

  typedef logic master_idx_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2,
    S_TURN = 2'd3
  } arb_state_e;

  function automatic arb_state_e owner_state(input master_idx_t idx);
    return idx ? S_OWN1 : S_OWN0;
  endfunction

endpackage : h80bus_arb_pkg
`default_nettype wire

// File: rtl/h80bus_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : h80bus_rr_pick
// Purpose  : Combinational two-way round-robin pick. With a single requester
//            that requester wins; with both requesting, the one that did not
//            own the bus last wins.
// Ports    : req   in  [1:0] - request vector, bit i for master i
//            last  in  1     - master that owned the bus most recently
//            valid out 1     - at least one request present
//            idx   out 1     - chosen master (meaningful when valid)
// Revision : 1.0 - initial release
// ============================================================================
module h80bus_rr_pick
  import h80bus_arb_pkg::*;
(
  input  logic [1:0]  req,
  input  master_idx_t last,
  output logic        valid,
  output master_idx_t idx
);

  always_comb begin
    valid = |req;
    if (req == 2'b11) begin
      idx = ~last;
    end else begin
      // Single or no requester: bit 1 set means master 1, otherwise master 0.
      idx = req[1];
    end
  end

endmodule : h80bus_rr_pick
`default_nettype wire

// File: rtl/h80bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : h80bus_arbiter
// Purpose  : Shares one downstream h80 bus between master 0 (CPU) and
//            master 1 (debug/DMA). Round-robin grant, handover only at
//            transaction boundaries, one dead TURN cycle after each release,
//            and an optional burst limit that preempts a long-running owner.
// Ports    : clk, reset                      - clock, sync active-high reset
//            m_req[i]      in                - master i wants the bus
//            m_gnt[i]      out (registered)  - master i owns the bus
//            m_iorq_n[i], m_mreq_n[i] in     - master strobes
//            m_addr/m_cmd/m_wdata[i] in      - master address/command/data
//            m_rdata       out               - downstream read data
//            m_wait_n[i]   out               - wait back to master i
//            iorq_n, mreq_n, bus_addr, bus_cmd, bus_wdata out - downstream
//            bus_rdata, bus_wait_n in        - downstream response
// Revision : 1.0 - initial release
// ============================================================================
module h80bus_arbiter
  import h80bus_arb_pkg::*;
#(
  parameter int BUS_ADDR_WIDTH = 16,
  parameter int BUS_CMD_WIDTH  = 3,
  parameter int BUS_DATA_WIDTH = 32,
  parameter int MAX_BURST      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m_req    [2],
  output logic                      m_gnt    [2],
  input  logic                      m_iorq_n [2],
  input  logic                      m_mreq_n [2],
  input  logic [BUS_ADDR_WIDTH-1:0] m_addr   [2],
  input  logic [BUS_CMD_WIDTH-1:0]  m_cmd    [2],
  input  logic [BUS_DATA_WIDTH-1:0] m_wdata  [2],
  output logic [BUS_DATA_WIDTH-1:0] m_rdata,
  output logic                      m_wait_n [2],
  output logic                      iorq_n,
  output logic                      mreq_n,
  output logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  output logic [BUS_CMD_WIDTH-1:0]  bus_cmd,
  output logic [BUS_DATA_WIDTH-1:0] bus_wdata,
  input  logic [BUS_DATA_WIDTH-1:0] bus_rdata,
  input  logic                      bus_wait_n
);

  // A zero-width counter is not legal, so the disabled case keeps one bit.
  localparam int CNT_W = (MAX_BURST == 0) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  master_idx_t      last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic        owner_valid;
  master_idx_t owner_idx;
  logic        own_active;
  logic        own_done;
  logic        other_req;
  logic        burst_hit;
  logic        release_ok;
  logic        pick_valid;
  master_idx_t pick_idx;

  // --------------------------------------------------------------------------
  // Owner decode from the registered state
  // --------------------------------------------------------------------------
  assign owner_valid = (state_q == S_OWN0) || (state_q == S_OWN1);
  assign owner_idx   = (state_q == S_OWN1);

  assign own_active = owner_valid && (!m_iorq_n[owner_idx] || !m_mreq_n[owner_idx]);
  assign own_done   = own_active && bus_wait_n;
  assign other_req  = m_req[~owner_idx];

  generate
    if (MAX_BURST == 0) begin : g_no_preempt
      assign burst_hit = 1'b0;
    end else begin : g_preempt
      assign burst_hit = (burst_cnt_q >= BURST_LIMIT);
    end
  endgenerate

  // Handover is only allowed between transactions, never while a strobe is
  // held low, so an in-flight access always completes on its original owner.
  assign release_ok = owner_valid && !own_active &&
                      (!m_req[owner_idx] || (burst_hit && other_req));

  h80bus_rr_pick u_pick (
    .req   ({m_req[1], m_req[0]}),
    .last  (last_owner_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // --------------------------------------------------------------------------
  // Downstream mux and wait fan-back (combinational on the registered owner)
  // --------------------------------------------------------------------------
  always_comb begin
    iorq_n      = 1'b1;
    mreq_n      = 1'b1;
    bus_addr    = '0;
    bus_cmd     = '0;
    bus_wdata   = '0;
    m_wait_n[0] = 1'b0;
    m_wait_n[1] = 1'b0;
    if (owner_valid) begin
      iorq_n              = m_iorq_n[owner_idx];
      mreq_n              = m_mreq_n[owner_idx];
      bus_addr            = m_addr[owner_idx];
      bus_cmd             = m_cmd[owner_idx];
      bus_wdata           = m_wdata[owner_idx];
      m_wait_n[owner_idx] = bus_wait_n;
    end
  end

  assign m_rdata = bus_rdata;

  // --------------------------------------------------------------------------
  // Arbitration FSM next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      S_IDLE, S_TURN: begin
        burst_cnt_d = '0;
        if (pick_valid) begin
          state_d      = owner_state(pick_idx);
          last_owner_d = pick_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN0, S_OWN1: begin
        if (release_ok) begin
          state_d     = S_TURN;
          burst_cnt_d = '0;
        end else if (own_done && (burst_cnt_q != BURST_LIMIT)) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Grants are decoded from the next state so m_gnt is a true flop output.
  assign gnt_d = {state_d == S_OWN1, state_d == S_OWN0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_q        <= 2'b00;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign m_gnt[0] = gnt_q[0];
  assign m_gnt[1] = gnt_q[1];

endmodule : h80bus_arbiter
`default_nettype wire

// File: tb/tb_h80bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_h80bus_arbiter
// Purpose  : Self-checking bench. Two arbiters share all inputs: u_dut with
//            MAX_BURST = 4 and u_dut_nb with MAX_BURST = 0. A vector table of
//            per-cycle stimulus and expected grants is queued and compared.
// Revision : 1.0 - initial release
// ============================================================================
module tb_h80bus_arbiter;

  localparam int AW = 16;
  localparam int CW = 3;
  localparam int DW = 32;

  localparam logic [AW-1:0] ADDR0 = 16'h1234;
  localparam logic [DW-1:0] WDAT0 = 32'hDEADBEEF;
  localparam logic [CW-1:0] CMD0  = 3'h5;
  localparam logic [AW-1:0] ADDR1 = 16'hBEEF;
  localparam logic [DW-1:0] WDAT1 = 32'h0BADF00D;
  localparam logic [CW-1:0] CMD1  = 3'h2;

  logic          clk = 1'b0;
  logic          reset;
  logic          m_req    [2];
  logic          m_iorq_n [2];
  logic          m_mreq_n [2];
  logic [AW-1:0] m_addr   [2];
  logic [CW-1:0] m_cmd    [2];
  logic [DW-1:0] m_wdata  [2];
  logic [DW-1:0] bus_rdata;
  logic          bus_wait_n;

  logic          m_gnt [2], m_wait_n [2];
  logic [DW-1:0] m_rdata;
  logic          iorq_n, mreq_n;
  logic [AW-1:0] bus_addr;
  logic [CW-1:0] bus_cmd;
  logic [DW-1:0] bus_wdata;

  logic          nb_gnt [2], nb_wait_n [2];
  logic [DW-1:0] nb_rdata;
  logic          nb_iorq_n, nb_mreq_n;
  logic [AW-1:0] nb_addr;
  logic [CW-1:0] nb_cmd;
  logic [DW-1:0] nb_wdata;

  always #5 clk = ~clk;

  h80bus_arbiter #(.BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW), .MAX_BURST(4)) u_dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_gnt(m_gnt), .m_iorq_n(m_iorq_n),
    .m_mreq_n(m_mreq_n), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_wait_n(m_wait_n), .iorq_n(iorq_n), .mreq_n(mreq_n),
    .bus_addr(bus_addr), .bus_cmd(bus_cmd), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_wait_n(bus_wait_n)
  );

  h80bus_arbiter #(.BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW), .BUS_DATA_WIDTH(DW), .MAX_BURST(0)) u_dut_nb (
    .clk(clk), .reset(reset), .m_req(m_req), .m_gnt(nb_gnt), .m_iorq_n(m_iorq_n),
    .m_mreq_n(m_mreq_n), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_rdata(nb_rdata), .m_wait_n(nb_wait_n), .iorq_n(nb_iorq_n), .mreq_n(nb_mreq_n),
    .bus_addr(nb_addr), .bus_cmd(nb_cmd), .bus_wdata(nb_wdata),
    .bus_rdata(bus_rdata), .bus_wait_n(bus_wait_n)
  );

  // s0/s1 are {iorq_n, mreq_n} of each master; req bit i is master i.
  typedef struct {
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    s0;
    logic [1:0]    s1;
    logic          wn;
    logic [DW-1:0] rd;
    logic [1:0]    gnt;
    logic [1:0]    gnt_nb;
    int            cnt;      // expected u_dut burst count, -1 = not checked
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rst, input logic [1:0] req, input logic [1:0] s0,
                     input logic [1:0] s1, input logic wn, input logic [DW-1:0] rd,
                     input logic [1:0] gnt, input logic [1:0] gnt_nb, input int cnt);
    vec_t v;
    v.rst = rst; v.req = req; v.s0 = s0; v.s1 = s1; v.wn = wn; v.rd = rd;
    v.gnt = gnt; v.gnt_nb = gnt_nb; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input int idx, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got 0x%0h expected 0x%0h", idx, name, act, exp);
    end
  endtask

  task automatic compare(input int idx);
    vec_t          e;
    logic [1:0]    es;
    logic [AW-1:0] ea;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    e  = sb.pop_front();
    es = 2'b11; ea = '0; ec = '0; ed = '0;
    if (e.gnt == 2'b01) begin
      es = e.s0; ea = ADDR0; ec = CMD0; ed = WDAT0;
    end else if (e.gnt == 2'b10) begin
      es = e.s1; ea = ADDR1; ec = CMD1; ed = WDAT1;
    end
    chk(idx, "m_gnt",    64'({m_gnt[1], m_gnt[0]}),       64'(e.gnt));
    chk(idx, "nb_gnt",   64'({nb_gnt[1], nb_gnt[0]}),     64'(e.gnt_nb));
    chk(idx, "iorq_n",   64'(iorq_n),                     64'(es[1]));
    chk(idx, "mreq_n",   64'(mreq_n),                     64'(es[0]));
    chk(idx, "bus_addr", 64'(bus_addr),                   64'(ea));
    chk(idx, "bus_cmd",  64'(bus_cmd),                    64'(ec));
    chk(idx, "bus_wdata",64'(bus_wdata),                  64'(ed));
    chk(idx, "m_wait_n", 64'({m_wait_n[1], m_wait_n[0]}), 64'(e.gnt & {2{e.wn}}));
    chk(idx, "m_rdata",  64'(m_rdata),                    64'(e.rd));
    if (e.cnt >= 0) begin
      chk(idx, "burst_cnt", 64'(u_dut.burst_cnt_q), 64'(e.cnt));
    end
  endtask

  initial begin
    // Reset state, then simultaneous request: m0 wins, write passes through,
    // m1 strobes while waiting are ignored.
    add(1, 2'b00, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00, -1);
    add(0, 2'b11, 2'b10, 2'b10, 1, 0, 2'b01, 2'b01, -1);
    add(0, 2'b11, 2'b11, 2'b10, 1, 0, 2'b01, 2'b01, 1);
    // Four completions in total, then preemption of m0 by m1.
    add(0, 2'b11, 2'b10, 2'b10, 1, 0, 2'b01, 2'b01, -1);
    add(0, 2'b11, 2'b11, 2'b10, 1, 0, 2'b01, 2'b01, -1);
    add(0, 2'b11, 2'b10, 2'b10, 1, 0, 2'b01, 2'b01, -1);
    add(0, 2'b11, 2'b11, 2'b10, 1, 0, 2'b01, 2'b01, -1);
    add(0, 2'b11, 2'b10, 2'b10, 1, 0, 2'b01, 2'b01, -1);
    add(0, 2'b11, 2'b11, 2'b10, 1, 0, 2'b01, 2'b01, 4);
    add(0, 2'b11, 2'b11, 2'b10, 1, 0, 2'b00, 2'b01, 0);
    add(0, 2'b11, 2'b11, 2'b10, 1, 0, 2'b10, 2'b01, -1);
    // m1 drops its request, m0 re-granted after TURN.
    add(0, 2'b01, 2'b11, 2'b11, 1, 0, 2'b10, 2'b01, -1);
    add(0, 2'b01, 2'b11, 2'b11, 1, 0, 2'b00, 2'b01, -1);
    // m0 read stalled 3 cycles, drops m_req mid-transaction.
    add(0, 2'b01, 2'b10, 2'b11, 0, 32'h11111111, 2'b01, 2'b01, -1);
    add(0, 2'b00, 2'b10, 2'b11, 0, 32'h11111111, 2'b01, 2'b01, -1);
    add(0, 2'b00, 2'b10, 2'b11, 0, 32'h11111111, 2'b01, 2'b01, -1);
    add(0, 2'b00, 2'b10, 2'b11, 1, 32'hCAFEF00D, 2'b01, 2'b01, -1);
    add(0, 2'b00, 2'b11, 2'b11, 1, 0, 2'b01, 2'b01, -1);
    add(0, 2'b00, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00, -1);
    // m1 alone, I/O access stalled, reset in the middle of it.
    add(0, 2'b10, 2'b11, 2'b11, 1, 0, 2'b00, 2'b00, -1);
    add(0, 2'b10, 2'b11, 2'b01, 0, 0, 2'b10, 2'b10, -1);
    add(1, 2'b11, 2'b11, 2'b01, 0, 0, 2'b10, 2'b10, -1);
    add(0, 2'b11, 2'b11, 2'b01, 1, 0, 2'b00, 2'b00, 0);
    // Both requesting after reset: m0 wins. m0 runs 10 transactions; only
    // the MAX_BURST = 0 instance lets it keep the bus throughout.
    for (int k = 24; k <= 42; k++) begin
      add(0, 2'b11, (k % 2 == 0) ? 2'b10 : 2'b11, 2'b11, 1, 0,
          (k <= 31) ? 2'b01 : ((k == 32) ? 2'b00 : 2'b10), 2'b01, (k == 31) ? 4 : -1);
    end
    add(0, 2'b10, 2'b11, 2'b11, 1, 0, 2'b10, 2'b01, -1);
    add(0, 2'b10, 2'b11, 2'b11, 1, 0, 2'b10, 2'b00, -1);
    add(0, 2'b10, 2'b11, 2'b11, 1, 0, 2'b10, 2'b10, -1);

    reset       = 1'b1;
    m_req[0]    = 1'b0;  m_req[1]    = 1'b0;
    m_iorq_n[0] = 1'b1;  m_iorq_n[1] = 1'b1;
    m_mreq_n[0] = 1'b1;  m_mreq_n[1] = 1'b1;
    m_addr[0]   = ADDR0; m_addr[1]   = ADDR1;
    m_cmd[0]    = CMD0;  m_cmd[1]    = CMD1;
    m_wdata[0]  = WDAT0; m_wdata[1]  = WDAT1;
    bus_rdata   = '0;
    bus_wait_n  = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset       = vecs[i].rst;
      m_req[0]    = vecs[i].req[0];
      m_req[1]    = vecs[i].req[1];
      m_iorq_n[0] = vecs[i].s0[1];
      m_mreq_n[0] = vecs[i].s0[0];
      m_iorq_n[1] = vecs[i].s1[1];
      m_mreq_n[1] = vecs[i].s1[0];
      bus_wait_n  = vecs[i].wn;
      bus_rdata   = vecs[i].rd;
      sb.push_back(vecs[i]);
      @(negedge clk);
      compare(i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_h80bus_arbiter
`default_nettype wire
